// File: rtl/qbus_dl11_mux.sv
// qbus_dl11_mux: multi-line DL11-compatible serial line unit on the QBUS.
// Each line exposes RCSR/RBUF/XCSR/XBUF at BASE+8k, a byte-stream TX/RX port,
// a paced transmitter and two vectored interrupt sources (RX, TX) that are
// served in fixed priority order with IAKO daisy-chain pass-through.
module qbus_dl11_mux #(
   parameter int          CHANNELS = 1,
   parameter logic [15:0] BASE     = 16'o177560,
   parameter logic [15:0] VECTOR   = 16'o000060,
   parameter int          TX_DELAY = 500
) (
   input  logic                  pin_clk,
   input  logic                  pin_init_n,
   input  logic [15:0]           pin_ad_n,
   output logic [15:0]           ad_n_out,
   output logic                  ad_oe,
   input  logic                  pin_sync_n,
   input  logic                  pin_din_n,
   input  logic                  pin_dout_n,
   input  logic                  pin_wtbt_n,
   input  logic                  pin_iako_n,
   output logic                  pin_rply_n,
   output logic                  pin_virq_n,
   output logic                  iako_out_n,
   output logic [8*CHANNELS-1:0] tx_data,
   output logic [CHANNELS-1:0]   tx_valid,
   input  logic [CHANNELS-1:0]   tx_ready,
   input  logic [8*CHANNELS-1:0] rx_data,
   input  logic [CHANNELS-1:0]   rx_valid
);

   localparam int NSRC  = 2 * CHANNELS;
   localparam int CNT_W = (TX_DELAY > 1) ? $clog2(TX_DELAY) : 1;

   // bus cycle states
   localparam logic [1:0] B_IDLE = 2'd0;
   localparam logic [1:0] B_ACK1 = 2'd1;
   localparam logic [1:0] B_ACK2 = 2'd2;
   localparam logic [1:0] B_PASS = 2'd3;

   // kind of the bus cycle being answered
   localparam logic [1:0] K_RD  = 2'd0;
   localparam logic [1:0] K_WR  = 2'd1;
   localparam logic [1:0] K_VEC = 2'd2;

   // transmitter engine states
   localparam logic [1:0] TX_IDLE = 2'd0;
   localparam logic [1:0] TX_SEND = 2'd1;
   localparam logic [1:0] TX_WAIT = 2'd2;

   logic [15:0]         ad_val;
   logic [15:0]         offs;
   logic                in_range;
   logic [CHANNELS-1:0] hit_now;
   logic [7:0]          wdata;

   logic                sync_seen;
   logic                sel;
   logic [CHANNELS-1:0] ch_hit;
   logic [1:0]          reg_idx;
   logic                addr_odd;

   logic [1:0]          bus_st;
   logic [1:0]          kind;
   logic                start_rd;
   logic                start_wr;
   logic                start_vec;
   logic                strobe_hi;
   logic                bus_wr;
   logic                bus_rbuf_clr;
   logic [15:0]         rd_word;
   logic [15:0]         vec_word;
   logic                have_win;
   logic [3:0]          win;

   logic [CHANNELS-1:0] rx_done_v;
   logic [CHANNELS-1:0] rx_ovr_v;
   logic [CHANNELS-1:0] rx_ie_v;
   logic [CHANNELS-1:0] tx_ie_v;
   logic [CHANNELS-1:0] tx_rdy_v;
   logic [7:0]          rx_buf_a [CHANNELS];
   logic [NSRC-1:0]     req_v;
   logic [NSRC-1:0]     ack_v;

   assign ad_val   = ~pin_ad_n;
   assign wdata    = ~pin_ad_n[7:0];
   assign offs     = ad_val - BASE;
   assign in_range = (ad_val >= BASE) && (offs[15:3] < 13'(CHANNELS));

   // Decode which line the address on the bus belongs to.
   always_comb begin
      hit_now = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         hit_now[k] = in_range && (offs[15:3] == 13'(k));
      end
   end

   // Latch the address once per SYNC assertion; selection ends with SYNC.
   always_ff @(posedge pin_clk or negedge pin_init_n) begin
      if (!pin_init_n) begin
         sync_seen <= 1'b0;
         sel       <= 1'b0;
         ch_hit    <= '0;
         reg_idx   <= 2'd0;
         addr_odd  <= 1'b0;
      end else if (pin_sync_n) begin
         sync_seen <= 1'b0;
         sel       <= 1'b0;
         ch_hit    <= '0;
      end else if (!sync_seen) begin
         sync_seen <= 1'b1;
         sel       <= in_range;
         ch_hit    <= hit_now;
         reg_idx   <= offs[2:1];
         addr_odd  <= offs[0];
      end
   end

   assign start_rd  = (bus_st == B_IDLE) && sel && !pin_din_n;
   assign start_wr  = (bus_st == B_IDLE) && sel && pin_din_n && !pin_dout_n;
   assign start_vec = (bus_st == B_IDLE) && !start_rd && !start_wr &&
                      !pin_iako_n && !pin_din_n;
   assign bus_wr    = start_wr && !(!pin_wtbt_n && addr_odd);

   // The strobe whose release ends the current cycle depends on its kind.
   always_comb begin
      case (kind)
         K_RD:    strobe_hi = pin_din_n;
         K_WR:    strobe_hi = pin_dout_n;
         K_VEC:   strobe_hi = pin_din_n | pin_iako_n;
         default: strobe_hi = 1'b1;
      endcase
   end

   assign bus_rbuf_clr = (bus_st == B_ACK1) && (kind == K_RD) &&
                         !strobe_hi && (reg_idx == 2'd1);

   // Read data multiplexer for the selected line and register.
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (ch_hit[k]) begin
            case (reg_idx)
               2'd0:    rd_word = {8'h00, rx_done_v[k], rx_ie_v[k], 6'b0};
               2'd1:    rd_word = {rx_ovr_v[k], 7'b0, rx_buf_a[k]};
               2'd2:    rd_word = {8'h00, tx_rdy_v[k], tx_ie_v[k], 6'b0};
               default: rd_word = '0;
            endcase
         end
      end
   end

   // Fixed priority: lowest source index (ch0 RX, ch0 TX, ch1 RX, ...) wins.
   always_comb begin
      have_win = 1'b0;
      win      = '0;
      for (int s = NSRC - 1; s >= 0; s--) begin
         if (req_v[s]) begin
            have_win = 1'b1;
            win      = 4'(s);
         end
      end
   end

   assign vec_word = VECTOR + {10'd0, win, 2'b00};

   // Acknowledge exactly the source whose vector is being driven.
   always_comb begin
      ack_v = '0;
      for (int s = 0; s < NSRC; s++) begin
         ack_v[s] = start_vec && have_win && (win == 4'(s));
      end
   end

   assign pin_virq_n = ~|req_v;
   assign iako_out_n = (bus_st == B_PASS) ? pin_iako_n : 1'b1;

   // Bus handshake: data/vector after E0, reply after E1, release on strobe high.
   always_ff @(posedge pin_clk or negedge pin_init_n) begin
      if (!pin_init_n) begin
         bus_st     <= B_IDLE;
         kind       <= K_RD;
         ad_oe      <= 1'b0;
         ad_n_out   <= 16'hFFFF;
         pin_rply_n <= 1'b1;
      end else begin
         case (bus_st)
            B_IDLE: begin
               if (start_rd) begin
                  kind     <= K_RD;
                  ad_n_out <= ~rd_word;
                  ad_oe    <= 1'b1;
                  bus_st   <= B_ACK1;
               end else if (start_wr) begin
                  kind   <= K_WR;
                  bus_st <= B_ACK1;
               end else if (start_vec) begin
                  if (have_win) begin
                     kind     <= K_VEC;
                     ad_n_out <= ~vec_word;
                     ad_oe    <= 1'b1;
                     bus_st   <= B_ACK1;
                  end else begin
                     bus_st <= B_PASS;
                  end
               end
            end
            B_ACK1: begin
               if (strobe_hi) begin
                  ad_oe      <= 1'b0;
                  ad_n_out   <= 16'hFFFF;
                  pin_rply_n <= 1'b1;
                  bus_st     <= B_IDLE;
               end else begin
                  pin_rply_n <= 1'b0;
                  bus_st     <= B_ACK2;
               end
            end
            B_ACK2: begin
               if (strobe_hi) begin
                  ad_oe      <= 1'b0;
                  ad_n_out   <= 16'hFFFF;
                  pin_rply_n <= 1'b1;
                  bus_st     <= B_IDLE;
               end
            end
            B_PASS: begin
               if (pin_iako_n) begin
                  bus_st <= B_IDLE;
               end
            end
            default: bus_st <= B_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_line
      logic             done_q;
      logic             ovr_q;
      logic             rie_q;
      logic             tie_q;
      logic [7:0]       rbuf_q;
      logic [7:0]       tbuf_q;
      logic [1:0]       tst_q;
      logic [CNT_W-1:0] tcnt_q;
      logic             rcond_d;
      logic             tcond_d;
      logic             rreq_q;
      logic             treq_q;
      logic             hit_wr;
      logic             wr_rcsr;
      logic             wr_xcsr;
      logic             wr_xbuf;
      logic             rbuf_clr;
      logic             tx_idle;
      logic             rcond;
      logic             tcond;

      assign hit_wr   = bus_wr && ch_hit[g];
      assign wr_rcsr  = hit_wr && (reg_idx == 2'd0);
      assign wr_xcsr  = hit_wr && (reg_idx == 2'd2);
      assign wr_xbuf  = hit_wr && (reg_idx == 2'd3);
      assign rbuf_clr = bus_rbuf_clr && ch_hit[g];
      assign tx_idle  = (tst_q == TX_IDLE);
      assign rcond    = rie_q && done_q;
      assign tcond    = tie_q && tx_idle;

      // Receiver: a new byte always wins; overrun only if the old one was unread.
      always_ff @(posedge pin_clk or negedge pin_init_n) begin
         if (!pin_init_n) begin
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            rie_q  <= 1'b0;
            rbuf_q <= 8'h00;
         end else begin
            if (wr_rcsr) begin
               rie_q <= wdata[6];
            end
            if (rx_valid[g]) begin
               rbuf_q <= rx_data[8*g +: 8];
               done_q <= 1'b1;
               ovr_q  <= done_q && !rbuf_clr;
            end else if (rbuf_clr) begin
               done_q <= 1'b0;
               ovr_q  <= 1'b0;
            end
         end
      end

      // Transmitter: hand the byte off, then hold ready low for the pacing delay.
      always_ff @(posedge pin_clk or negedge pin_init_n) begin
         if (!pin_init_n) begin
            tst_q  <= TX_IDLE;
            tcnt_q <= '0;
            tbuf_q <= 8'h00;
            tie_q  <= 1'b0;
         end else begin
            if (wr_xcsr) begin
               tie_q <= wdata[6];
            end
            case (tst_q)
               TX_IDLE: begin
                  if (wr_xbuf) begin
                     tbuf_q <= wdata;
                     tst_q  <= TX_SEND;
                  end
               end
               TX_SEND: begin
                  if (wr_xbuf) begin
                     tbuf_q <= wdata;
                  end
                  if (tx_ready[g]) begin
                     tcnt_q <= CNT_W'(TX_DELAY - 1);
                     tst_q  <= TX_WAIT;
                  end
               end
               TX_WAIT: begin
                  if (tcnt_q == '0) begin
                     tst_q <= TX_IDLE;
                  end else begin
                     tcnt_q <= tcnt_q - CNT_W'(1);
                  end
               end
               default: tst_q <= TX_IDLE;
            endcase
         end
      end

      // Interrupt requests fire on a rising condition and drop on ack or fall.
      always_ff @(posedge pin_clk or negedge pin_init_n) begin
         if (!pin_init_n) begin
            rcond_d <= 1'b0;
            tcond_d <= 1'b0;
            rreq_q  <= 1'b0;
            treq_q  <= 1'b0;
         end else begin
            rcond_d <= rcond;
            tcond_d <= tcond;
            rreq_q  <= rcond && !ack_v[2*g]   && (rreq_q || !rcond_d);
            treq_q  <= tcond && !ack_v[2*g+1] && (treq_q || !tcond_d);
         end
      end

      assign rx_done_v[g]      = done_q;
      assign rx_ovr_v[g]       = ovr_q;
      assign rx_ie_v[g]        = rie_q;
      assign tx_ie_v[g]        = tie_q;
      assign tx_rdy_v[g]       = tx_idle;
      assign rx_buf_a[g]       = rbuf_q;
      assign req_v[2*g]        = rreq_q;
      assign req_v[2*g+1]      = treq_q;
      assign tx_data[8*g +: 8] = tbuf_q;
      assign tx_valid[g]       = (tst_q == TX_SEND);
   end

endmodule

// File: tb/tb_qbus_dl11_mux.sv
// tb_qbus_dl11_mux: directed bench for a two-line qbus_dl11_mux with a short
// transmitter pacing delay; expected values are hand-computed constants.
module tb_qbus_dl11_mux;

   localparam int          CH   = 2;
   localparam int          TXD  = 20;
   localparam logic [15:0] BASE = 16'o177560;
   localparam logic [15:0] VEC  = 16'o000060;

   localparam int K_READ  = 0;
   localparam int K_WRITE = 1;
   localparam int K_IAKO  = 2;

   logic              clk;
   logic              pin_init_n;
   logic [15:0]       pin_ad_n;
   logic [15:0]       ad_n_out;
   logic              ad_oe;
   logic              pin_sync_n;
   logic              pin_din_n;
   logic              pin_dout_n;
   logic              pin_wtbt_n;
   logic              pin_iako_n;
   logic              pin_rply_n;
   logic              pin_virq_n;
   logic              iako_out_n;
   logic [8*CH-1:0]   tx_data;
   logic [CH-1:0]     tx_valid;
   logic [CH-1:0]     tx_ready;
   logic [8*CH-1:0]   rx_data;
   logic [CH-1:0]     rx_valid;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] rd;
   int          lat;
   logic        oe;
   logic        ipass;
   logic        rel;

   qbus_dl11_mux #(
      .CHANNELS (CH),
      .BASE     (BASE),
      .VECTOR   (VEC),
      .TX_DELAY (TXD)
   ) dut (
      .pin_clk    (clk),
      .pin_init_n (pin_init_n),
      .pin_ad_n   (pin_ad_n),
      .ad_n_out   (ad_n_out),
      .ad_oe      (ad_oe),
      .pin_sync_n (pin_sync_n),
      .pin_din_n  (pin_din_n),
      .pin_dout_n (pin_dout_n),
      .pin_wtbt_n (pin_wtbt_n),
      .pin_iako_n (pin_iako_n),
      .pin_rply_n (pin_rply_n),
      .pin_virq_n (pin_virq_n),
      .iako_out_n (iako_out_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid)
   );

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One bus cycle (read, write or interrupt acknowledge); reply wait is bounded.
   task automatic applyStimulus(input int k, input logic [15:0] addr,
                                input logic [15:0] wd, input logic byte_n,
                                output logic [15:0] rdata, output int rlat,
                                output logic oe_seen, output logic iako_low,
                                output logic released);
      rdata    = 16'h0000;
      rlat     = 99;
      oe_seen  = 1'b0;
      iako_low = 1'b0;
      if (k != K_IAKO) begin
         @(negedge clk);
         pin_ad_n   = ~addr;
         pin_sync_n = 1'b0;
      end
      @(negedge clk);
      if (k == K_READ) begin
         pin_ad_n  = 16'hFFFF;
         pin_din_n = 1'b0;
      end else if (k == K_WRITE) begin
         pin_ad_n   = ~wd;
         pin_wtbt_n = byte_n;
         pin_dout_n = 1'b0;
      end else begin
         pin_iako_n = 1'b0;
         pin_din_n  = 1'b0;
      end
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (ad_oe) begin
            oe_seen = 1'b1;
            rdata   = ~ad_n_out;
         end
         if (!iako_out_n) iako_low = 1'b1;
         if (!pin_rply_n) begin
            rlat = i;
            break;
         end
      end
      pin_din_n  = 1'b1;
      pin_dout_n = 1'b1;
      pin_iako_n = 1'b1;
      pin_wtbt_n = 1'b1;
      pin_ad_n   = 16'hFFFF;
      @(negedge clk);
      released   = pin_rply_n && !ad_oe && iako_out_n;
      pin_sync_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulseRx(input int ch, input logic [7:0] b);
      @(negedge clk);
      rx_data[8*ch +: 8] = b;
      rx_valid[ch]       = 1'b1;
      @(negedge clk);
      rx_valid = '0;
   endtask

   task automatic acceptTx();
      @(negedge clk);
      tx_ready = 2'b01;
      @(negedge clk);
      tx_ready = 2'b00;
   endtask

   // directed sequence
   initial begin
      pin_init_n = 1'b0;
      pin_ad_n   = 16'hFFFF;
      pin_sync_n = 1'b1;
      pin_din_n  = 1'b1;
      pin_dout_n = 1'b1;
      pin_wtbt_n = 1'b1;
      pin_iako_n = 1'b1;
      tx_ready   = '0;
      rx_data    = '0;
      rx_valid   = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ad_oe", 32'(ad_oe), 32'h0);
      checkOutput("rst_ad_n_out", 32'(ad_n_out), 32'hFFFF);
      checkOutput("rst_rply", 32'(pin_rply_n), 32'h1);
      checkOutput("rst_virq", 32'(pin_virq_n), 32'h1);
      checkOutput("rst_iako_out", 32'(iako_out_n), 32'h1);
      checkOutput("rst_tx_valid", 32'(tx_valid), 32'h0);
      pin_init_n = 1'b1;
      @(negedge clk);

      $display("[TB] XCSR read after reset");
      applyStimulus(K_READ, BASE + 16'd4, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("xcsr_rst", 32'(rd), 32'o000200);
      checkOutput("xcsr_rply_lat", 32'(lat), 32'd2);
      checkOutput("xcsr_oe", 32'(oe), 32'h1);
      checkOutput("xcsr_release", 32'(rel), 32'h1);

      $display("[TB] transmit 0x41, drop write while busy");
      applyStimulus(K_WRITE, BASE + 16'd6, 16'h0041, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("xbuf_wr_lat", 32'(lat), 32'd2);
      checkOutput("tx_valid_1", 32'(tx_valid), 32'h1);
      checkOutput("tx_data_41", 32'(tx_data[7:0]), 32'h41);
      applyStimulus(K_READ, BASE + 16'd4, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("xcsr_busy_send", 32'(rd), 32'h0);
      acceptTx();
      checkOutput("tx_valid_after_acc", 32'(tx_valid), 32'h0);
      applyStimulus(K_WRITE, BASE + 16'd6, 16'h0055, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("xbuf_drop_data", 32'(tx_data[7:0]), 32'h41);
      checkOutput("xbuf_drop_valid", 32'(tx_valid), 32'h0);
      repeat (30) @(negedge clk);

      $display("[TB] overwrite pending byte, ready still low at delay edge");
      applyStimulus(K_WRITE, BASE + 16'd6, 16'h0042, 1'b1, rd, lat, oe, ipass, rel);
      applyStimulus(K_WRITE, BASE + 16'd6, 16'h0043, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("xbuf_overwrite", 32'(tx_data[7:0]), 32'h43);
      acceptTx();
      repeat (TXD - 3) @(negedge clk);
      applyStimulus(K_READ, BASE + 16'd4, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("xcsr_at_delay", 32'(rd), 32'h0);
      repeat (30) @(negedge clk);
      applyStimulus(K_READ, BASE + 16'd4, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("xcsr_after_delay", 32'(rd), 32'o000200);

      $display("[TB] ready returns exactly TX_DELAY clocks after acceptance");
      applyStimulus(K_WRITE, BASE + 16'd6, 16'h0044, 1'b1, rd, lat, oe, ipass, rel);
      acceptTx();
      repeat (TXD - 2) @(negedge clk);
      applyStimulus(K_READ, BASE + 16'd4, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("xcsr_delay_plus1", 32'(rd), 32'o000200);
      checkOutput("tx_data_44", 32'(tx_data[7:0]), 32'h44);

      $display("[TB] receive with overrun");
      pulseRx(0, 8'h31);
      pulseRx(0, 8'h32);
      applyStimulus(K_READ, BASE, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("rcsr_done", 32'(rd), 32'o000200);
      applyStimulus(K_READ, BASE + 16'd2, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("rbuf_overrun", 32'(rd), 32'o100062);
      applyStimulus(K_READ, BASE, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("rcsr_cleared", 32'(rd), 32'h0);
      applyStimulus(K_READ, BASE + 16'd2, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("rbuf_ovr_cleared", 32'(rd), 32'h0032);

      $display("[TB] byte arrives in the RBUF read clear cycle");
      pulseRx(0, 8'h34);
      fork
         begin
            repeat (3) @(negedge clk);
            rx_data[7:0] = 8'h33;
            rx_valid[0]  = 1'b1;
            @(negedge clk);
            rx_valid[0]  = 1'b0;
         end
         applyStimulus(K_READ, BASE + 16'd2, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      join
      checkOutput("rbuf_race_old", 32'(rd), 32'h0034);
      applyStimulus(K_READ, BASE, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("rcsr_race_done", 32'(rd), 32'o000200);
      applyStimulus(K_READ, BASE + 16'd2, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("rbuf_race_new", 32'(rd), 32'h0033);

      $display("[TB] interrupts and vectors");
      applyStimulus(K_WRITE, BASE + 16'd8, 16'h0040, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("virq_idle", 32'(pin_virq_n), 32'h1);
      pulseRx(1, 8'h61);
      repeat (2) @(negedge clk);
      checkOutput("virq_ch1_rx", 32'(pin_virq_n), 32'h0);
      applyStimulus(K_WRITE, BASE + 16'd4, 16'h0040, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("virq_two", 32'(pin_virq_n), 32'h0);
      applyStimulus(K_IAKO, 16'h0, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("vec1", 32'(rd), 32'(VEC + 16'd4));
      checkOutput("vec1_lat", 32'(lat), 32'd2);
      checkOutput("vec1_no_pass", 32'(ipass), 32'h0);
      applyStimulus(K_IAKO, 16'h0, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("vec2", 32'(rd), 32'(VEC + 16'd8));
      repeat (2) @(negedge clk);
      checkOutput("virq_served", 32'(pin_virq_n), 32'h1);
      applyStimulus(K_IAKO, 16'h0, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("iako_none_rply", 32'(lat), 32'd99);
      checkOutput("iako_none_oe", 32'(oe), 32'h0);
      checkOutput("iako_none_pass", 32'(ipass), 32'h1);
      checkOutput("iako_none_release", 32'(rel), 32'h1);

      $display("[TB] byte writes and decode boundary");
      applyStimulus(K_WRITE, BASE + 16'd4, 16'h0000, 1'b1, rd, lat, oe, ipass, rel);
      applyStimulus(K_WRITE, BASE + 16'd5, 16'hFFFF, 1'b0, rd, lat, oe, ipass, rel);
      checkOutput("byte_hi_lat", 32'(lat), 32'd2);
      applyStimulus(K_READ, BASE + 16'd4, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("byte_hi_ie", 32'(rd), 32'o000200);
      applyStimulus(K_WRITE, BASE + 16'd4, 16'h00FF, 1'b0, rd, lat, oe, ipass, rel);
      applyStimulus(K_READ, BASE + 16'd4, 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("byte_lo_ie", 32'(rd), 32'o000300);
      applyStimulus(K_READ, BASE + 16'(8 * CH), 16'h0, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("oor_rd_rply", 32'(lat), 32'd99);
      checkOutput("oor_rd_oe", 32'(oe), 32'h0);
      applyStimulus(K_WRITE, BASE + 16'(8 * CH), 16'h0040, 1'b1, rd, lat, oe, ipass, rel);
      checkOutput("oor_wr_rply", 32'(lat), 32'd99);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/qbus_dl11_mux.md
# qbus_dl11_mux

Parametrised multi-channel DL11-compatible serial line unit, a QBUS slave for the 1801VM3 replica system. It decodes `CHANNELS` sets of four terminal registers (RCSR/RBUF/XCSR/XBUF) on the inverted address/data bus and answers with RPLY. Each channel has a byte-stream transmit and receive port, programmable transmitter pacing and per-channel vectored interrupts with fixed priority and IAKO daisy-chain pass-through. It replaces the behavioural console model with a synthesizable block that also serves additional terminal lines.

## Interface
- `CHANNELS`, 1: number of lines, 1..8.
- `BASE`, 16'o177560: word address of channel 0 RCSR; channel k at BASE+8k.
- `VECTOR`, 16'o000060: channel 0 RX vector; channel k RX at VECTOR+8k, TX at VECTOR+8k+4.
- `TX_DELAY`, 500: clocks from byte acceptance until XCSR ready returns, ≥1.
- `pin_clk` in 1: single clock; all logic on rising edge.
- `pin_init_n` in 1: reset, asynchronous, active-low.
- `pin_ad_n` in 16: inverted AD bus, sampled.
- `ad_n_out` out 16: inverted read data / vector; valid when `ad_oe`=1.
- `ad_oe` out 1: AD bus drive enable.
- `pin_sync_n`, `pin_din_n`, `pin_dout_n`, `pin_wtbt_n`, `pin_iako_n` in 1 each: QBUS strobes, active-low, synchronous to `pin_clk`.
- `pin_rply_n` out 1: reply, active-low.
- `pin_virq_n` out 1: vectored interrupt request, active-low.
- `iako_out_n` out 1: IAKO passed to the next device in the chain.
- `tx_data` out 8*CHANNELS, `tx_valid` out CHANNELS, `tx_ready` in CHANNELS: per-line transmit stream.
- `rx_data` in 8*CHANNELS, `rx_valid` in CHANNELS: per-line receive strobe, one-cycle pulse.

## Operation
- Address phase: at the first edge sampling `pin_sync_n`=0, latch `addr`=~`pin_ad_n` and `wtbt`; `sel`=1 when addr in [BASE, BASE+8·CHANNELS-1]. `sel` clears when `pin_sync_n`=1.
- RCSR: bit7 done (RO), bit6 IE (RW); other bits read 0. RBUF: bits7:0 data, bit15 overrun; read clears done and overrun.
- XCSR: bit7 ready (RO), bit6 IE (RW). XBUF write: latch low byte to `tx_data`, ready=0, `tx_valid`=1; reads return 0.
- Byte write (`pin_wtbt_n`=0 during DOUT): addr[0]=0 writes bits7:0; addr[0]=1 writes nothing. Writes to RBUF ignored. XBUF write while ready=0 overwrites the pending byte when `tx_valid`=1; otherwise it is dropped.
- TX engine per line: IDLE -> (XBUF write) SEND -> (`tx_valid`&`tx_ready`) WAIT, counter loads TX_DELAY-1 -> (counter=0) IDLE, ready=1.
- RX: `rx_valid` latches the byte, done=1; if done already 1, overrun=1 and the data is overwritten.
- Interrupts: per source, request flop set on a rising edge of IE&done (RX) or IE&ready (TX), including setting IE while the flag is already 1. It clears when the condition falls or when the source is acknowledged. `pin_virq_n`=~|requests.
- Priority: ch0 RX > ch0 TX > ch1 RX > … fixed.
- Vector cycle: at the first edge sampling `pin_iako_n`=0 with `pin_din_n`=0, freeze the winner. If one exists, drive its vector and clear its request. If none, hold `iako_out_n`=`pin_iako_n` and never drive the bus.

## Timing
- Reset: `ad_oe`=0, `ad_n_out`=16'hFFFF, `pin_rply_n`=1, `pin_virq_n`=1, `iako_out_n`=1, `tx_valid`=0, all IE/done/overrun=0, ready=1, TX engines IDLE.
- Read: edge E0 first samples `pin_din_n`=0 with `sel`. After E0, `ad_oe`=1 and data valid; after E1, `pin_rply_n`=0. The RBUF clear side effect occurs at E1.
- Write: register updated at E0 first sampling `pin_dout_n`=0 with `sel`; `pin_rply_n`=0 after E1.
- Vector: same two-cycle timing as read.
- Termination: first edge sampling DIN/DOUT/IAKO high drops `ad_oe` and `pin_rply_n` in that cycle. No re-trigger until the strobe is seen high.
- `rx_valid` in the same cycle as an RBUF read: the new byte wins, done=1, overrun=0.
- Reset mid-transfer: immediate release of `pin_rply_n` and `ad_oe`; the frozen vector winner is discarded.

## Test plan
- Reset, read BASE+4 (XCSR) -> 16'o000200 driven, `pin_rply_n` low 2 clocks after DIN.
- Write XBUF=0x41 -> `tx_valid`=1, `tx_data`=0x41. Hold `tx_ready`=1 one cycle -> XCSR reads 0, then 16'o000200 exactly TX_DELAY clocks later.
- Two `rx_valid` pulses (0x31, 0x32) without reading -> RBUF reads 16'o100062; a second read returns RCSR done=0.
- CHANNELS=2: enable ch1 RX IE, pulse ch1 RX, then set ch0 XCSR IE=1 -> `pin_virq_n`=0. First IAKO vector = VECTOR+4 (ch0 TX); second = VECTOR+8.
- IAKO with no pending request -> `iako_out_n` follows `pin_iako_n`, `ad_oe` stays 0, no RPLY.
- Byte write 0xFF to XCSR high byte (BASE+5) -> IE unchanged. Address BASE+8·CHANNELS -> no RPLY.
